// File: rtl/serial_nibble_adder_pkg.sv
// Shared definitions for the serial nibble adder.
//   state_e  : controller state encoding (2'd3 is unused and recovers to idle)
//   NIBBLE_W : width of the reused adder stage
package serial_nibble_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_nibble_adder_add4_rca.sv
// Combinational 4-bit ripple-carry adder stage.
//   a, b : nibble operands
//   cin  : carry in
//   s    : nibble sum
//   cout : carry out of bit 3
module add4_rca
  import serial_nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle P_WIDTH-bit adder reusing one 4-bit adder stage, one nibble per clock.
//   i_w_clk, i_w_rst_n        : clock, synchronous active-low reset
//   i_w_valid / o_w_ready     : operand handshake (ready only in idle)
//   i_w_a, i_w_b, i_w_cin     : operands and initial carry
//   o_w_valid / i_w_ready     : result handshake (valid only in done)
//   o_w_s, o_w_cout, o_w_ovf  : registered sum, carry out, signed overflow
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int unsigned P_WIDTH = 16
) (
  input  logic               i_w_clk,
  input  logic               i_w_rst_n,
  input  logic               i_w_valid,
  output logic               o_w_ready,
  input  logic [P_WIDTH-1:0] i_w_a,
  input  logic [P_WIDTH-1:0] i_w_b,
  input  logic               i_w_cin,
  output logic               o_w_valid,
  input  logic               i_w_ready,
  output logic [P_WIDTH-1:0] o_w_s,
  output logic               o_w_cout,
  output logic               o_w_ovf
);

  localparam int unsigned P_NIBBLES = P_WIDTH / NIBBLE_W;
  localparam int unsigned IdxW      = (P_NIBBLES > 1) ? $clog2(P_NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(P_NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [P_WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d;
  logic [P_WIDTH-1:0] s_q, s_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] stage_a, stage_b, stage_s;
  logic                stage_cout;

  assign stage_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign stage_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  add4_rca u_add4 (
    .a    (stage_a),
    .b    (stage_b),
    .cin  (carry_q),
    .s    (stage_s),
    .cout (stage_cout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    psum_d    = psum_q;
    s_d       = s_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    o_w_ready = 1'b0;
    o_w_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          a_d     = i_w_a;
          b_d     = i_w_b;
          carry_d = i_w_cin;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        psum_d[NIBBLE_W*idx_q +: NIBBLE_W] = stage_s;
        carry_d = stage_cout;
        if (idx_q == LastIdx) begin
          // psum_d already holds the final nibble, so the result is complete here.
          s_d     = psum_d;
          cout_d  = stage_cout;
          ovf_d   = (a_q[P_WIDTH-1] == b_q[P_WIDTH-1]) && (psum_d[P_WIDTH-1] != a_q[P_WIDTH-1]);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        o_w_valid = 1'b1;
        if (i_w_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_w_s    = s_q;
  assign o_w_cout = cout_q;
  assign o_w_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder (P_WIDTH = 16).
module tb_serial_nibble_adder;

  localparam int unsigned W = 16;
  localparam int unsigned Nibbles = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int checks;
  int errors;

  serial_nibble_adder #(
    .P_WIDTH (W)
  ) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .i_w_valid (in_valid),
    .o_w_ready (in_ready),
    .i_w_a     (a),
    .i_w_b     (b),
    .i_w_cin   (cin),
    .o_w_valid (out_valid),
    .i_w_ready (out_ready),
    .o_w_s     (s),
    .o_w_cout  (cout),
    .o_w_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands while idle and let the accept edge happen.
  task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin);
    check_eq("ready_before_accept", 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for the result; latency counted in edges after the accept edge.
  task automatic wait_done(input string tag);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      check_eq({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      cycles++;
    end
    check_eq({tag, "_latency"}, 32'(cycles), 32'(Nibbles));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic [W-1:0] exp_s, input logic exp_cout,
                        input logic exp_ovf);
    out_ready = 1'b1;
    start_op(op_a, op_b, op_cin);
    wait_done(tag);
    check_eq({tag, "_s"}, 32'(s), 32'(exp_s));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    tick();
    check_eq({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      tick();
    end
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_s", 32'(s), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_valid_after", 32'(out_valid), 32'd0);

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("chain1",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("chain2",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("mixed",   16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_done("bp");
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_ready", 32'(in_ready), 32'd0);
      check_eq("bp_s", 32'(s), 32'h3333);
      check_eq("bp_cout", 32'(cout), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
    check_eq("bp_hold_s", 32'(s), 32'h3333);
    run_op("bp_next", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Abort mid-operation at idx == 2.
    start_op(16'h1234, 16'h1111, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_s", 32'(s), 32'd0);
    check_eq("abort_cout", 32'(cout), 32'd0);
    check_eq("abort_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
